// File: rtl/audio_capture.sv
// Audio capture sequencer: pops ADC samples, keeps every DECIM-th one as a 6-bit RAM word,
// and tracks the peak magnitude of the capture with a holdoff-qualified hit pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no capture; waits for record_en (after it has been seen low)
//   S_WAIT  | capture armed; waits for a non-empty ADC FIFO
//   S_READ  | pop strobe high; sample latched, peak/hit evaluated
//   S_WRITE | RAM write of the latched sample at the current address
//   S_DONE  | capture window filled; rec_done high until record_en drops
module audio_capture #(
    parameter logic [17:0] REC_START = 18'd0,
    parameter logic [17:0] REC_END   = 18'd16395,
    parameter logic [3:0]  DECIM     = 4'd1,
    parameter logic [15:0] HOLDOFF   = 16'd4800
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        record_en,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [4:0]  threshold,
    output logic        read_audio_in,
    output logic [17:0] mem_addr,
    output logic [5:0]  mem_data,
    output logic        mem_wren,
    output logic        rec_done,
    output logic        hit_detect,
    output logic [4:0]  peak_level
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;

    // DECIM of zero behaves like one rather than wrapping to sixteen.
    localparam logic [3:0] DECIM_LAST = (DECIM == 4'd0) ? 4'd0 : DECIM - 4'd1;

    state_t      state_q;
    logic [17:0] addr_q;
    logic [5:0]  sample_q;
    logic [4:0]  peak_q;
    logic [3:0]  dcnt_q;
    logic [15:0] hold_q;
    logic        read_q;
    logic        wren_q;
    logic        done_q;
    logic        hit_q;
    logic        arm_q;
    logic        settle_q;

    logic [5:0]  sample_in;
    logic [5:0]  sample_neg;
    logic [4:0]  mag;
    logic        unused_sample_lsbs;

    assign sample_in          = left_channel_audio_in[31:26];
    assign sample_neg         = 6'd0 - sample_in;
    assign unused_sample_lsbs = ^left_channel_audio_in[25:0];

    // -32 has no 5-bit magnitude, so it saturates to 31.
    always_comb begin
        mag = sample_in[4:0];
        if (sample_in[5]) begin
            mag = (sample_in == 6'b100000) ? 5'd31 : sample_neg[4:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= 18'd0;
            sample_q <= 6'd0;
            peak_q   <= 5'd0;
            dcnt_q   <= 4'd0;
            hold_q   <= 16'd0;
            read_q   <= 1'b0;
            wren_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            arm_q    <= 1'b0;
            settle_q <= 1'b0;
        end else begin
            read_q <= 1'b0;
            wren_q <= 1'b0;
            hit_q  <= 1'b0;
            // A capture may only start once record_en has been seen low since reset.
            if (!record_en) begin
                arm_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (record_en && arm_q) begin
                        state_q  <= S_WAIT;
                        addr_q   <= REC_START;
                        peak_q   <= 5'd0;
                        dcnt_q   <= 4'd0;
                        hold_q   <= 16'd0;
                        settle_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!record_en) begin
                        state_q <= S_IDLE;
                    end else if (settle_q) begin
                        settle_q <= 1'b0;
                    end else if (audio_in_available) begin
                        state_q <= S_READ;
                        read_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    sample_q <= sample_in;
                    if (mag > peak_q) begin
                        peak_q <= mag;
                    end
                    if (hold_q == 16'd0) begin
                        if (mag >= threshold) begin
                            hit_q  <= 1'b1;
                            hold_q <= HOLDOFF;
                        end
                    end else begin
                        hold_q <= hold_q - 16'd1;
                    end
                    if (!record_en) begin
                        state_q <= S_IDLE;
                    end else if (dcnt_q == DECIM_LAST) begin
                        dcnt_q  <= 4'd0;
                        state_q <= S_WRITE;
                        wren_q  <= 1'b1;
                    end else begin
                        // Skipped samples take an extra WAIT cycle so the FIFO flag can settle.
                        dcnt_q   <= dcnt_q + 4'd1;
                        state_q  <= S_WAIT;
                        settle_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!record_en) begin
                        state_q <= S_IDLE;
                    end else if (addr_q == REC_END) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q  <= addr_q + 18'd1;
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (!record_en) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign read_audio_in = read_q;
    assign mem_addr      = addr_q;
    assign mem_data      = sample_q;
    assign mem_wren      = wren_q;
    assign rec_done      = done_q;
    assign hit_detect    = hit_q;
    assign peak_level    = peak_q;

endmodule

// File: tb/tb_audio_capture.sv
// Bench for audio_capture: two instances (DECIM 1 and 3) share stimulus and are checked
// every cycle against a transaction-level model of the capture rules.
module tb_audio_capture;

    logic        clk;
    logic        resetn;
    logic        record_en;
    logic        avail;
    logic [31:0] data_in;
    logic [4:0]  threshold;

    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [1:0]  done;
    logic [1:0]  hit;
    logic [17:0] addr [2];
    logic [5:0]  data [2];
    logic [4:0]  peak [2];

    int checks = 0;
    int errors = 0;

    audio_capture #(
        .REC_START(18'd0), .REC_END(18'd3), .DECIM(4'd1), .HOLDOFF(16'd4)
    ) u_dut_a (
        .CLOCK_50(clk), .resetn(resetn), .record_en(record_en),
        .audio_in_available(avail), .left_channel_audio_in(data_in), .threshold(threshold),
        .read_audio_in(rd[0]), .mem_addr(addr[0]), .mem_data(data[0]), .mem_wren(wr[0]),
        .rec_done(done[0]), .hit_detect(hit[0]), .peak_level(peak[0])
    );

    audio_capture #(
        .REC_START(18'd10), .REC_END(18'd12), .DECIM(4'd3), .HOLDOFF(16'd4)
    ) u_dut_b (
        .CLOCK_50(clk), .resetn(resetn), .record_en(record_en),
        .audio_in_available(avail), .left_channel_audio_in(data_in), .threshold(threshold),
        .read_audio_in(rd[1]), .mem_addr(addr[1]), .mem_data(data[1]), .mem_wren(wr[1]),
        .rec_done(done[1]), .hit_detect(hit[1]), .peak_level(peak[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [5:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 31) v = 31;
        return v;
    endfunction

    // Per-instance configuration and model state.
    int          rs_m [2] = '{0, 10};
    int          re_m [2] = '{3, 12};
    int          dec_m [2] = '{1, 3};
    int          ho_m = 4;
    bit          sess [2];
    bit          armed [2];
    bit          exp_wr [2];
    bit          exp_hit [2];
    bit          exp_done [2];
    int          nreads [2];
    int          peak_m [2];
    int          hold_m [2];
    int          gap [2];
    int          waddr [2];
    logic [5:0]  pend_data [2];
    bit          prev_avail;
    int          nrd_obs [2] = '{0, 0};
    int          nwr_obs [2] = '{0, 0};
    int          nhit_obs [2] = '{0, 0};
    logic [5:0]  b_wdata [$];

    always @(negedge clk) begin
        logic [5:0] s;
        int         m;
        bit         nh, nw, nd, rd_ok;
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                chk($sformatf("rst_out%0d", i),
                    32'({rd[i], wr[i], done[i], hit[i], addr[i], data[i], peak[i]}), 32'd0);
                sess[i] = 0; armed[i] = 0; exp_wr[i] = 0; exp_hit[i] = 0; exp_done[i] = 0;
                nreads[i] = 0; peak_m[i] = 0; hold_m[i] = 0; gap[i] = 1000; waddr[i] = 0;
                pend_data[i] = 6'd0;
            end else begin
                chk($sformatf("hit%0d", i), 32'(hit[i]), 32'(exp_hit[i]));
                chk($sformatf("wren%0d", i), 32'(wr[i]), 32'(exp_wr[i]));
                chk($sformatf("done%0d", i), 32'(done[i]), 32'(exp_done[i]));
                chk($sformatf("peak%0d", i), 32'(peak[i]), 32'(peak_m[i]));
                chk($sformatf("addr%0d", i), 32'(addr[i]), 32'(waddr[i]));
                if (wr[i]) chk($sformatf("wdata%0d", i), 32'(data[i]), 32'(pend_data[i]));
                rd_ok = prev_avail && sess[i] && (gap[i] >= 3) && !exp_done[i];
                chk($sformatf("rd_legal%0d", i), 32'(rd[i] && !rd_ok), 32'd0);

                nh = 0; nw = 0;
                if (rd[i]) begin
                    nrd_obs[i]++;
                    gap[i] = 1;
                    s = data_in[31:26];
                    m = mag_of(s);
                    nreads[i]++;
                    nh = (m >= int'(threshold)) && (hold_m[i] == 0);
                    if (hold_m[i] == 0) begin
                        if (m >= int'(threshold)) hold_m[i] = ho_m;
                    end else begin
                        hold_m[i]--;
                    end
                    if (m > peak_m[i]) peak_m[i] = m;
                    nw = record_en && (nreads[i] % dec_m[i] == 0);
                    pend_data[i] = s;
                end else if (gap[i] < 1000) begin
                    gap[i]++;
                end
                nhit_obs[i] += int'(hit[i]);
                nd = (wr[i] && record_en && waddr[i] == re_m[i]) || (exp_done[i] && record_en);
                if (wr[i]) begin
                    nwr_obs[i]++;
                    if (i == 1) b_wdata.push_back(data[i]);
                    if (record_en && waddr[i] != re_m[i]) waddr[i]++;
                end
                if (!record_en) begin
                    sess[i] = 0;
                    armed[i] = 1;
                end else if (!sess[i] && armed[i]) begin
                    sess[i] = 1; peak_m[i] = 0; hold_m[i] = 0; nreads[i] = 0; waddr[i] = rs_m[i];
                end
                exp_hit[i] = nh;
                exp_wr[i] = nw;
                exp_done[i] = nd;
            end
        end
        prev_avail = avail;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_rd, base_wr, base_hit;
        resetn = 1'b0; record_en = 1'b0; avail = 1'b0; data_in = 32'd0; threshold = 5'd31;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();

        // Basic capture: every sample flagged (threshold 0), B sees samples numbered 1..9.
        threshold = 5'd0;
        avail = 1'b1;
        data_in = {6'd1, 26'($urandom)};
        record_en = 1'b1;
        for (int c = 0; c < 200 && !(done[0] && done[1]); c++) begin
            tick();
            data_in = {nrd_obs[1][5:0] + 6'd1, 26'($urandom)};
        end
        chk("a_done", 32'(done[0]), 32'd1);
        chk("b_done", 32'(done[1]), 32'd1);
        chk("a_writes", nwr_obs[0], 4);
        chk("b_reads", nrd_obs[1], 9);
        chk("b_writes", b_wdata.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("b_wdata_seq", (k < b_wdata.size()) ? 32'(b_wdata[k]) : 32'd0, 32'(3 * (k + 1)));
        end
        record_en = 1'b0;
        tick();
        chk("done_clear", 32'(done[0]), 32'd0);
        tick();

        // Saturating magnitude and holdoff.
        threshold = 5'd31;
        data_in = {6'b100000, 26'd0};
        base_rd = nrd_obs[0];
        base_hit = nhit_obs[0];
        record_en = 1'b1;
        for (int c = 0; c < 20 && nrd_obs[0] == base_rd; c++) tick();
        chk("hit_first_read", nrd_obs[0] - base_rd, 1);
        data_in = {6'b011111, 26'd0};
        for (int c = 0; c < 60 && !done[0]; c++) tick();
        chk("hit_peak", 32'(peak[0]), 32'd31);
        chk("hit_count", nhit_obs[0] - base_hit, 1);
        record_en = 1'b0;
        repeat (2) tick();

        // FIFO empty for 100 cycles while waiting.
        avail = 1'b0;
        record_en = 1'b1;
        base_rd = nrd_obs[0];
        repeat (100) tick();
        chk("stall_reads", nrd_obs[0] - base_rd, 0);
        chk("stall_addr", 32'(addr[0]), 32'd0);
        avail = 1'b1;
        for (int c = 0; c < 60 && !done[0]; c++) tick();
        chk("stall_done", 32'(done[0]), 32'd1);
        record_en = 1'b0;
        repeat (2) tick();

        // record_en dropped during the write that follows a read.
        record_en = 1'b1;
        base_rd = nrd_obs[0];
        base_wr = nwr_obs[0];
        for (int c = 0; c < 20 && nrd_obs[0] == base_rd; c++) tick();
        record_en = 1'b0;
        repeat (20) tick();
        chk("abort_reads", nrd_obs[0] - base_rd, 1);
        chk("abort_writes", nwr_obs[0] - base_wr, 1);
        chk("abort_done", 32'(done[0]), 32'd0);

        // Randomized traffic.
        record_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            tick();
            avail = ($urandom_range(0, 3) != 0);
            data_in = $urandom;
            threshold = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 29) == 0) record_en = !record_en;
        end

        // Reset asserted during a write.
        record_en = 1'b0;
        repeat (2) tick();
        avail = 1'b1;
        record_en = 1'b1;
        for (int c = 0; c < 50 && !wr[0]; c++) @(negedge clk);
        chk("rst_wait_wr", 32'(wr[0]), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_wren", 32'(wr[0]), 32'd0);
        chk("rst_read", 32'(rd[0]), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_peak", 32'(peak[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 resetn = 1'b1;
        base_rd = nrd_obs[0];
        repeat (20) tick();
        chk("post_rst_idle", nrd_obs[0] - base_rd, 0);
        record_en = 1'b0;
        tick();
        record_en = 1'b1;
        for (int c = 0; c < 60 && !done[0]; c++) tick();
        chk("restart_done", 32'(done[0]), 32'd1);
        record_en = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
